multisim_pull_rr_arbiter: RTL and testbench
===========================================

Name: multisim_pull_rr_arbiter

Overview:
- Shares one multisim pull-client stream among NUM_REQ local consumers.
- Sits between the pull client's data_vld/data/data_rdy and N consumer ports.
- Grants one consumer at a time, round-robin, with a burst cap so no consumer starves the others.
- Data path is a zero-latency pass-through; the arbiter only steers valid/ready and keeps per-consumer beat statistics.

Parameters:
- NUM_REQ, 4, number of consumers (2..16).
- DATA_WIDTH, 64, width of the pulled data word.
- BURST_MAX, 4, maximum beats per grant before forced release (>=1).
- CNT_WIDTH, 16, width of each per-consumer beat counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when 0, no new grants and no transfers.
- src_vld  input  1  from pull client data_vld.
- src_data  input  DATA_WIDTH  from pull client data.
- src_rdy  output  1  to pull client data_rdy.
- req  input  NUM_REQ  consumer i wants data.
- dst_rdy  input  NUM_REQ  consumer i accepts a beat this cycle.
- dst_vld  output  NUM_REQ  one-hot valid to the granted consumer.
- dst_data  output  DATA_WIDTH  broadcast copy of src_data.
- grant_vld  output  1  a grant is active.
- grant_id  output  $clog2(NUM_REQ)  index of the granted consumer.
- beat_cnt  output  NUM_REQ*CNT_WIDTH  per-consumer transferred-beat counters, packed with consumer 0 in the LSBs.

Behaviour:
- Reset (async assert, sync release) clears: state=IDLE, grant_vld=0, grant_id=0, rr pointer=0, burst count=0, all beat_cnt=0.
- src_rdy=0 and dst_vld=0 under reset.
- States are IDLE and GRANTED.
- IDLE:
  - If enable && |req, pick the first i with req[i]=1, scanning from the pointer upward with wrap.
  - Next cycle: state=GRANTED, grant_id=i, grant_vld=1, burst count=0.
  - Otherwise stay in IDLE.
- GRANTED, with g = grant_id:
  - dst_vld[g] = src_vld && enable; all other dst_vld bits are 0.
  - src_rdy = enable && dst_rdy[g]. This is combinational: src_rdy may assert while src_vld=0, matching client semantics where rdy advances an empty slot.
  - transfer = src_vld && src_rdy. On each transfer, beat_cnt[g]++ (wraps at 2^CNT_WIDTH) and burst count++.
- Release from GRANTED goes to IDLE and sets pointer = (g+1) mod NUM_REQ. Release happens when either:
  - transfer occurs with burst count == BURST_MAX-1, or
  - req[g]==0 is sampled.
- Simultaneous transfer and req[g] drop: the beat completes and is counted, and the grant is released the same edge.
- Every release costs exactly one IDLE cycle. Consequences:
  - Worst-case grant latency is 1 + (NUM_REQ-1)*(BURST_MAX+1) cycles of competing bursts.
  - Peak throughput for a single consumer is BURST_MAX/(BURST_MAX+1).
- enable=0 while GRANTED: grant is held, src_rdy=0, dst_vld=0, no counting. If req[g] drops meanwhile, release proceeds normally.
- A consumer that drops req with a beat pending loses nothing. The pull client holds data/data_vld until rdy, so the beat goes to the next grantee.
- Reset mid-burst: everything returns to reset values immediately. Any beat not yet accepted stays in the client.
- dst_data = src_data at all times. No storage, no added latency.
- Requires NUM_REQ is a power of two or pointer wrap uses an explicit compare. The implementation uses the explicit compare.

Decomposition:
- Package multisim_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANTED} multisim_arb_state_e;
  - localparam function for id width ($clog2 guarded to a minimum of 1).
- Sub-module multisim_rr_picker: combinational.
  - Inputs: req vector, pointer.
  - Outputs: found flag and index of the first set bit at or after the pointer, with wrap.
  - Parameterised by NUM_REQ.
  - Reused by future push-side arbiters.

Test Plan:
- Single consumer, req=0001, dst_rdy=1, src_vld=1 constant, BURST_MAX=4 -> 4 beats, 1 IDLE cycle, repeating; beat_cnt[0]=8 after 10 cycles past first grant.
- All four req=1111, all dst_rdy=1, src_vld=1 -> grant order 0,1,2,3,0 with 4 beats each; after 20 cycles every beat_cnt=4.
- Consumer 2 granted with dst_rdy[2]=0 for 5 cycles -> src_rdy=0, dst_vld[2]=1, src_data stable, beat_cnt[2] unchanged; dst_rdy[2]=1 -> one transfer the same cycle.
- req[1] drops in the same cycle as a transfer on grant 1 -> beat counted (beat_cnt[1]+1), state IDLE next edge, pointer=2, next grant goes to 2 if req[2]=1.
- enable=0 mid-burst, 3 cycles -> no src_rdy, no counting, grant_id held; enable=1 -> burst resumes and finishes the remaining beats up to BURST_MAX.
- rst_n pulsed low asynchronously (between edges) mid-burst -> outputs zero before the next clk edge; after release, first grant goes to consumer 0 and all counters restart at 0.

Source files
------------

// File: rtl/multisim_arb_pkg.sv
// Shared types and helpers for the multisim
// pull-side arbiters.
package multisim_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } multisim_arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multisim_rr_picker.sv
// Round-robin picker: first set request at
// or after ptr, wrapping past the top index.
module multisim_rr_picker
  import multisim_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  // Scan high offset to low so the nearest
  // request to ptr is the one left standing.
  always_comb begin
    logic [IW:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ))
        pos = pos - (IW+1)'(NUM_REQ);
      if (req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/multisim_pull_rr_arbiter.sv
// Shares one pull-client stream among NUM_REQ
// consumers, round-robin with a burst cap.
module multisim_pull_rr_arbiter
  import multisim_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         src_vld,
  input  logic [DATA_WIDTH-1:0]        src_data,
  output logic                         src_rdy,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           dst_rdy,
  output logic [NUM_REQ-1:0]           dst_vld,
  output logic [DATA_WIDTH-1:0]        dst_data,
  output logic                         grant_vld,
  output logic [IW-1:0]                grant_id,
  output logic [NUM_REQ*CNT_WIDTH-1:0] beat_cnt
);

  localparam int BW = id_width(BURST_MAX) + 1;

  multisim_arb_state_e state_q;
  logic [IW-1:0]        gid_q;
  logic [IW-1:0]        ptr_q;
  logic [BW-1:0]        burst_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  logic          granted;
  logic          xfer;
  logic          last_beat;
  logic          rel;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_nxt;

  multisim_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign granted   = (state_q == ARB_GRANTED);
  assign src_rdy   = granted & enable
                   & dst_rdy[gid_q];
  assign xfer      = src_vld & src_rdy;
  assign last_beat = xfer &&
    (burst_q == BW'(BURST_MAX - 1));
  assign rel       = granted &&
    (last_beat || !req[gid_q]);
  assign ptr_nxt   =
    (gid_q == IW'(NUM_REQ - 1)) ? '0
                                : gid_q + IW'(1);

  assign dst_data  = src_data;
  assign grant_vld = granted;
  assign grant_id  = gid_q;

  // Steer the client valid to the grantee only.
  always_comb begin
    dst_vld = '0;
    if (granted && enable && src_vld)
      dst_vld[gid_q] = 1'b1;
  end

  // Grant FSM: pick, hold for a burst, release
  // through one IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (enable && pick_found) begin
            state_q <= ARB_GRANTED;
            gid_q   <= pick_idx;
            burst_q <= '0;
          end
        end
        ARB_GRANTED: begin
          if (xfer)
            burst_q <= burst_q + BW'(1);
          if (rel) begin
            state_q <= ARB_IDLE;
            ptr_q   <= ptr_nxt;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Per-consumer beat counters, free-wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt_q[i] <= '0;
    end else if (xfer) begin
      cnt_q[gid_q] <= cnt_q[gid_q]
                    + CNT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign beat_cnt[i*CNT_WIDTH +: CNT_WIDTH] =
      cnt_q[i];
  end

endmodule

// File: tb/tb_multisim_pull_rr_arbiter.sv
// Directed bench with a behavioural reference
// model checked every cycle.
module tb_multisim_pull_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BM = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          src_vld;
  logic [DW-1:0] src_data;
  logic          src_rdy;
  logic [N-1:0]  req;
  logic [N-1:0]  dst_rdy;
  logic [N-1:0]  dst_vld;
  logic [DW-1:0] dst_data;
  logic          grant_vld;
  logic [1:0]    grant_id;
  logic [N*CW-1:0] beat_cnt;

  int nchk = 0;
  int nerr = 0;
  bit cmp_en = 0;

  multisim_pull_rr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .BURST_MAX(BM), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .src_vld(src_vld), .src_data(src_data),
    .src_rdy(src_rdy), .req(req),
    .dst_rdy(dst_rdy), .dst_vld(dst_vld),
    .dst_data(dst_data), .grant_vld(grant_vld),
    .grant_id(grant_id), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return beat_cnt[i*CW +: CW];
  endfunction

  // Reference model: who owns the stream, how many
  // beats of the burst are done, where the scan starts.
  bit m_gnt = 0;
  int m_own = 0;
  int m_ptr = 0;
  int m_beats = 0;
  int m_cnt [N] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin : model
    bit hit;
    int pick;
    bit moved;
    hit = 0;
    pick = 0;
    moved = 0;
    if (!rst_n) begin
      m_gnt <= 0;
      m_own <= 0;
      m_ptr <= 0;
      m_beats <= 0;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else if (!m_gnt) begin
      if (enable && req != 0) begin
        for (int k = 0; k < N; k++)
          if (!hit && req[(m_ptr + k) % N]) begin
            hit = 1;
            pick = (m_ptr + k) % N;
          end
        m_gnt <= 1;
        m_own <= pick;
        m_beats <= 0;
      end
    end else begin
      moved = src_vld && enable && dst_rdy[m_own];
      if (moved) begin
        m_cnt[m_own] <= (m_cnt[m_own] + 1) % 65536;
        m_beats <= m_beats + 1;
      end
      if ((moved && m_beats + 1 == BM) ||
          !req[m_own]) begin
        m_gnt <= 0;
        m_ptr <= (m_own + 1) % N;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] ev;
      logic erdy;
      ev = (m_gnt && enable && src_vld)
         ? N'(1 << m_own) : '0;
      erdy = m_gnt && enable && dst_rdy[m_own];
      chk("m_src_rdy", 64'(src_rdy), 64'(erdy));
      chk("m_dst_vld", 64'(dst_vld), 64'(ev));
      chk("m_grant_vld", 64'(grant_vld),
          64'(m_gnt));
      if (m_gnt)
        chk("m_grant_id", 64'(grant_id),
            64'(m_own));
      chk("m_dst_data", dst_data, src_data);
      for (int i = 0; i < N; i++)
        chk("m_beat_cnt", 64'(cnt(i)),
            64'(m_cnt[i]));
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req = '0;
    dst_rdy = '0;
    src_vld = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (grant_vld === 1'b1) got = 1;
    end
    nchk++;
    if (!got) begin
      nerr++;
      $display("FAIL %s: got no grant expected grant",
               nm);
    end
  endtask

  int gexp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    src_vld = 1'b0;
    src_data = 64'h0123_4567_89ab_cdef;
    req = '0;
    dst_rdy = '0;

    // Single consumer, streaming.
    do_reset();
    cmp_en = 1;
    chk("reset_gvld", 64'(grant_vld), 64'd0);
    chk("reset_cnt", 64'(beat_cnt), 64'd0);
    req = 4'b0001;
    dst_rdy = 4'b1111;
    src_vld = 1'b1;
    wait_grant("t1_grant");
    repeat (10) @(posedge clk);
    #1;
    chk("t1_cnt0", 64'(cnt(0)), 64'd8);
    chk("t1_model", 64'(m_cnt[0]), 64'd8);
    chk("t1_gvld", 64'(grant_vld), 64'd1);
    chk("t1_data", dst_data,
        64'h0123_4567_89ab_cdef);

    // Four consumers rotate with full bursts.
    do_reset();
    req = 4'b1111;
    dst_rdy = 4'b1111;
    src_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_gid0", 64'(grant_id), 64'd0);
    for (int k = 1; k < 5; k++) begin
      repeat (4) @(posedge clk);
      #1;
      chk("t2_idle", 64'(grant_vld), 64'd0);
      @(posedge clk);
      #1;
      chk("t2_gvld", 64'(grant_vld), 64'd1);
      chk("t2_gid", 64'(grant_id), 64'(gexp[k]));
    end
    for (int i = 0; i < N; i++)
      chk("t2_cnt", 64'(cnt(i)), 64'd4);

    // Consumer 2 stalls, then accepts.
    do_reset();
    src_data = 64'hdead_beef_0123_4567;
    req = 4'b0100;
    dst_rdy = 4'b0000;
    src_vld = 1'b1;
    wait_grant("t3_grant");
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_rdy", 64'(src_rdy), 64'd0);
      chk("t3_vld", 64'(dst_vld), 64'b0100);
      chk("t3_cnt", 64'(cnt(2)), 64'd0);
      chk("t3_data", dst_data,
          64'hdead_beef_0123_4567);
      @(negedge clk);
    end
    #1;
    dst_rdy = 4'b0100;
    #1;
    chk("t3_rdy_up", 64'(src_rdy), 64'd1);
    @(posedge clk);
    #1;
    chk("t3_cnt1", 64'(cnt(2)), 64'd1);

    // req[1] drops together with a transfer.
    do_reset();
    req = 4'b0110;
    dst_rdy = 4'b1111;
    src_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_gid1", 64'(grant_id), 64'd1);
    @(posedge clk);
    #1;
    chk("t4_cnt_a", 64'(cnt(1)), 64'd1);
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("t4_cnt_b", 64'(cnt(1)), 64'd2);
    chk("t4_idle", 64'(grant_vld), 64'd0);
    @(posedge clk);
    #1;
    chk("t4_gvld", 64'(grant_vld), 64'd1);
    chk("t4_gid2", 64'(grant_id), 64'd2);

    // enable low mid-burst.
    do_reset();
    req = 4'b0001;
    dst_rdy = 4'b1111;
    src_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_cnt2", 64'(cnt(0)), 64'd2);
    enable = 1'b0;
    #1;
    chk("t5_rdy", 64'(src_rdy), 64'd0);
    chk("t5_vld", 64'(dst_vld), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_hold", 64'(cnt(0)), 64'd2);
    chk("t5_gvld", 64'(grant_vld), 64'd1);
    chk("t5_gid", 64'(grant_id), 64'd0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_cnt3", 64'(cnt(0)), 64'd3);
    @(posedge clk);
    #1;
    chk("t5_cnt4", 64'(cnt(0)), 64'd4);
    chk("t5_rel", 64'(grant_vld), 64'd0);

    // Async reset mid-burst.
    req = 4'b1111;
    @(posedge clk);
    #1;
    chk("t6_gid1", 64'(grant_id), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rdy", 64'(src_rdy), 64'd0);
    chk("t6_vld", 64'(dst_vld), 64'd0);
    chk("t6_gvld", 64'(grant_vld), 64'd0);
    chk("t6_cnt", 64'(beat_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_gid0", 64'(grant_id), 64'd0);
    chk("t6_gvld1", 64'(grant_vld), 64'd1);
    @(posedge clk);
    #1;
    chk("t6_cnt0", 64'(cnt(0)), 64'd1);
    chk("t6_cnt1", 64'(cnt(1)), 64'd0);

    @(negedge clk);
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
